// File: rtl/sumres_display.sv
// rtl/sumres_display.sv - signed ALU result to BCD, 3-digit multiplexed 7-segment display (option: LEADING_ZERO_BLANK_EN)
module sumres_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] So,
    input  logic       flag,
    input  logic       Sel,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int         PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  mag_sh;
    logic [7:0]  bcd;
    logic [2:0]  bit_cnt;
    logic        neg_cap;

    logic [3:0]  units;
    logic [3:0]  tens;
    logic        neg;

    logic [PW-1:0] presc;
    logic [1:0]    digit_idx;

    logic [4:0]  mag_in;
    logic        neg_in;
    logic [7:0]  bcd_adj;
    logic [12:0] conv_next;
    logic        conv_last;
    logic [6:0]  digit_seg;
    logic [2:0]  digit_an;

    // Active-high decimal segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b0111111;
            4'd1:    dec7 = 7'b0000110;
            4'd2:    dec7 = 7'b1011011;
            4'd3:    dec7 = 7'b1001111;
            4'd4:    dec7 = 7'b1100110;
            4'd5:    dec7 = 7'b1101101;
            4'd6:    dec7 = 7'b1111101;
            4'd7:    dec7 = 7'b0000111;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1101111;
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    // Signed interpretation of the ALU outputs; a borrow means the result is So - 16.
    always_comb begin
        mag_in = {flag, So};
        neg_in = 1'b0;
        if (Sel) begin
            if (flag) begin
                mag_in = 5'd16 - {1'b0, So};
                neg_in = 1'b1;
            end else begin
                mag_in = {1'b0, So};
            end
        end
    end

    // Shift-add-3 step: correct each nibble, then shift the next magnitude bit in.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        conv_next = {bcd_adj, mag_sh} << 1;
    end

    assign conv_last = (bit_cnt == 3'd4);
    assign busy      = (state == CONV);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: a load only starts a conversion from IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (conv_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath; display registers are updated together on the final shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_sh  <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            neg_cap <= 1'b0;
            units   <= '0;
            tens    <= '0;
            neg     <= 1'b0;
        end else if (state == IDLE) begin
            if (load) begin
                mag_sh  <= mag_in;
                neg_cap <= neg_in;
                bcd     <= '0;
                bit_cnt <= '0;
            end
        end else begin
            {bcd, mag_sh} <= conv_next;
            bit_cnt       <= bit_cnt + 3'd1;
            if (conv_last) begin
                units <= conv_next[8:5];
                tens  <= conv_next[12:9];
                neg   <= neg_cap;
            end
        end
    end

    // Scan prescaler and digit index, free-running regardless of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            digit_idx <= 2'd0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc     <= '0;
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Pattern and enable for the digit currently selected.
    always_comb begin
        digit_seg = 7'b0000000;
        digit_an  = 3'b000;
        case (digit_idx)
            2'd0: begin
                digit_seg = dec7(units);
                digit_an  = 3'b001;
            end
            2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                digit_seg = (tens == 4'd0) ? 7'b0000000 : dec7(tens);
`else
                digit_seg = dec7(tens);
`endif
                digit_an  = 3'b010;
            end
            2'd2: begin
                digit_seg = neg ? 7'b1000000 : 7'b0000000;
                digit_an  = 3'b100;
            end
            default: begin
                digit_seg = 7'b0000000;
                digit_an  = 3'b000;
            end
        endcase
    end

    // Registered display outputs with board polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~digit_seg : digit_seg;
            an  <= SEG_ACTIVE_LOW ? ~digit_an : digit_an;
        end
    end

endmodule

// File: tb/tb_sumres_display.sv
// tb/tb_sumres_display.sv - self-checking bench for sumres_display
module tb_sumres_display;

    localparam int SCAN_DIV = 4;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] So = 4'd0;
    logic       flag = 1'b0;
    logic       Sel = 1'b0;
    logic       load = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] an;

    sumres_display #(
        .SCAN_DIV      (SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .So   (So),
        .flag (flag),
        .Sel  (Sel),
        .load (load),
        .busy (busy),
        .seg  (seg),
        .an   (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [3:0] so;
        logic       flg;
        logic       neg;
        int         tens;
        int         units;
    } vec_t;

    typedef struct {
        logic [6:0] sign;
        logic [6:0] tens;
        logic [6:0] units;
    } disp_t;

    int    passed = 0;
    int    total  = 0;
    disp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] seg_lo(input int d);
        case (d)
            0:       seg_lo = 7'b1000000;
            1:       seg_lo = 7'b1111001;
            2:       seg_lo = 7'b0100100;
            3:       seg_lo = 7'b0110000;
            4:       seg_lo = 7'b0011001;
            5:       seg_lo = 7'b0010010;
            6:       seg_lo = 7'b0000010;
            7:       seg_lo = 7'b1111000;
            8:       seg_lo = 7'b0000000;
            9:       seg_lo = 7'b0010000;
            default: seg_lo = BLANK;
        endcase
    endfunction

    function automatic disp_t expect_disp(input logic neg, input int tens, input int units);
        disp_t d;
        d.sign  = neg ? MINUS : BLANK;
        d.tens  = seg_lo(tens);
`ifdef LEADING_ZERO_BLANK_EN
        if (tens == 0) d.tens = BLANK;
`endif
        d.units = seg_lo(units);
        return d;
    endfunction

    // Observe a full scan round and record the pattern shown on each digit.
    task automatic capture(output disp_t d, output logic [2:0] seen);
        seen = 3'b000;
        d.sign = 'x;
        d.tens = 'x;
        d.units = 'x;
        for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
            @(negedge clk);
            case (an)
                3'b110: begin d.units = seg; seen[0] = 1'b1; end
                3'b101: begin d.tens  = seg; seen[1] = 1'b1; end
                3'b011: begin d.sign  = seg; seen[2] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic compare_display(input string name);
        disp_t      got;
        disp_t      exp;
        logic [2:0] seen;
        capture(got, seen);
        check({name, "_scan_seen"}, 32'(seen), 32'h7);
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_sign"},  32'(got.sign),  32'(exp.sign));
            check({name, "_tens"},  32'(got.tens),  32'(exp.tens));
            check({name, "_units"}, 32'(got.units), 32'(exp.units));
        end
    endtask

    // Pulse load for one edge (edge N); returns 1ns after edge N.
    task automatic start_load(input logic s, input logic [3:0] v, input logic f);
        @(negedge clk);
        Sel  = s;
        So   = v;
        flag = f;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("busy_after_load", 32'(busy), 32'd1);
    endtask

    // Count edges until busy drops, starting from a given edge count.
    task automatic wait_done(input int start, output int cycles);
        cycles = start;
        while (busy && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    vec_t vecs[9];

    initial begin
        int         cyc;
        logic [2:0] prev_an;
        int         run_len;
        int         transitions;

        vecs[0] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1, 7};
        vecs[1] = '{1'b1, 4'b1110, 1'b1, 1'b1, 0, 2};
        vecs[2] = '{1'b0, 4'b1110, 1'b1, 1'b0, 3, 0};
        vecs[3] = '{1'b1, 4'b0000, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1, 6};
        vecs[5] = '{1'b0, 4'b1111, 1'b1, 1'b0, 3, 1};
        vecs[6] = '{1'b1, 4'b0101, 1'b0, 1'b0, 0, 5};
        vecs[7] = '{1'b1, 4'b0001, 1'b1, 1'b1, 1, 5};
        vecs[8] = '{1'b0, 4'b1001, 1'b0, 1'b0, 0, 9};

        // Reset state.
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_seg",  32'(seg),  32'h7F);
        check("reset_an",   32'(an),   32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_clk_an",  32'(an),  32'b110);
        check("first_clk_seg", 32'(seg), 32'(seg_lo(0)));

        // Table-driven conversions.
        for (int i = 0; i < 9; i++) begin
            start_load(vecs[i].sel, vecs[i].so, vecs[i].flg);
            exp_q.push_back(expect_disp(vecs[i].neg, vecs[i].tens, vecs[i].units));
            wait_done(0, cyc);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd5);
            @(posedge clk);
            compare_display($sformatf("vec%0d", i));
        end

        // Second load during a conversion is ignored.
        start_load(1'b0, 4'b1001, 1'b0);
        exp_q.push_back(expect_disp(1'b0, 0, 9));
        @(negedge clk);
        Sel  = 1'b0;
        So   = 4'b1110;
        flag = 1'b1;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(posedge clk);
        #1;
        check("ignored_load_busy", 32'(busy), 32'd1);
        wait_done(2, cyc);
        check("ignored_load_latency", 32'(cyc), 32'd5);
        @(posedge clk);
        #1;
        check("ignored_load_no_restart", 32'(busy), 32'd0);
        compare_display("ignored_load");

        // Asynchronous reset mid-conversion discards the partial result.
        start_load(1'b0, 4'b1111, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_seg",  32'(seg),  32'h7F);
        check("midreset_an",   32'(an),   32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(expect_disp(1'b0, 0, 0));
        compare_display("after_reset");
        start_load(1'b1, 4'b1101, 1'b1);
        exp_q.push_back(expect_disp(1'b1, 0, 3));
        wait_done(0, cyc);
        check("post_reset_latency", 32'(cyc), 32'd5);
        @(posedge clk);
        compare_display("post_reset");

        // Load held high retriggers after each completed conversion.
        @(negedge clk);
        Sel  = 1'b0;
        So   = 4'b0001;
        flag = 1'b1;
        load = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(expect_disp(1'b0, 1, 7));
        wait_done(0, cyc);
        check("retrig_first_latency", 32'(cyc), 32'd5);
        @(posedge clk);
        #1;
        check("retrig_busy_again", 32'(busy), 32'd1);
        load = 1'b0;
        wait_done(0, cyc);
        check("retrig_second_latency", 32'(cyc), 32'd5);
        @(posedge clk);
        compare_display("retrig");

        // Scan order and dwell, continuing through a conversion.
        start_load(1'b1, 4'b1011, 1'b1);
        exp_q.push_back(expect_disp(1'b1, 0, 5));
        @(negedge clk);
        prev_an     = an;
        run_len     = 1;
        transitions = 0;
        for (int i = 0; i < 9 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (an == prev_an) begin
                run_len++;
            end else begin
                check("scan_order", 32'(an),
                      32'((prev_an == 3'b110) ? 3'b101 :
                          (prev_an == 3'b101) ? 3'b011 : 3'b110));
                if (transitions > 0) check("scan_dwell", 32'(run_len), 32'(SCAN_DIV));
                transitions++;
                run_len = 1;
                prev_an = an;
            end
        end
        check("scan_transitions_seen", 32'(transitions >= 7), 32'd1);
        check("scan_conv_done", 32'(busy), 32'd0);
        compare_display("scan_conv");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
